// File: rtl/mode7_camera_ctrl.sv
// mode7_camera_ctrl: per-frame Mode 7 camera angle/scroll update from buttons, sequenced on vsync falling edge.
// Optional CAM_AUTO_ROTATE_EN: frames with no rotate button advance angle by 1.
module mode7_camera_ctrl #(
  parameter int ANGLE_MAX  = 360,
  parameter int ANGLE_STEP = 1,
  parameter int MOVE_STEP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fwd,
  input  logic        btn_back,
  output logic [9:0]  angle,
  output logic [15:0] offsetx,
  output logic [15:0] offsety,
  output logic        frame_tick
);
  typedef enum logic [1:0] {IDLE, LATCH, ROTATE, MOVE} state_t;
  state_t state;
  logic [3:0] sync1, sync2, cmd;
  logic vsync_q, frame_evt, left, right, fwd, back;
  logic [9:0] angle_nxt;
  int a, up, dn, idle_rot, rot;
  assign frame_evt = vsync_q & ~vsync;
  assign {left, right, fwd, back} = cmd;
  always_comb begin
    a = 0;
    a[9:0] = angle;
    up = a + ANGLE_STEP >= ANGLE_MAX ? a + ANGLE_STEP - ANGLE_MAX : a + ANGLE_STEP;
    dn = a < ANGLE_STEP ? a + ANGLE_MAX - ANGLE_STEP : a - ANGLE_STEP;
`ifdef CAM_AUTO_ROTATE_EN
    idle_rot = a + 1 >= ANGLE_MAX ? 0 : a + 1;
`else
    idle_rot = a;
`endif
    rot = (left & ~right) ? up : (right & ~left) ? dn : (left | right) ? a : idle_rot;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      cmd        <= '0;
      vsync_q    <= 1'b1;
      state      <= IDLE;
      angle      <= '0;
      angle_nxt  <= '0;
      offsetx    <= '0;
      offsety    <= '0;
      frame_tick <= 1'b0;
    end else begin
      sync1      <= {btn_left, btn_right, btn_fwd, btn_back};
      sync2      <= sync1;
      vsync_q    <= vsync;
      frame_tick <= 1'b0;
      case (state)
        IDLE:   if (frame_evt) state <= LATCH;
        LATCH: begin
          cmd   <= sync2;
          state <= ROTATE;
        end
        ROTATE: begin
          angle_nxt <= 10'(rot);
          state     <= MOVE;
        end
        default: begin
          angle      <= angle_nxt;
          offsety    <= (fwd & ~back) ? offsety + 16'(MOVE_STEP) :
                        (back & ~fwd) ? offsety - 16'(MOVE_STEP) : offsety;
          frame_tick <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule
